// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: turns operation fields into 32-bit words with
// sequential byte addresses and streams them out through a small FIFO.
module instr_encoder #(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [5:0]        in_shamt,
    input  logic [1:0]        in_hw,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [15:0]       count,
    output logic [1:0]        dbg_state
);

    // Both streams use valid/ready: a transfer happens on the rising edge where
    // valid && ready; valid never depends on ready, and payload holds while valid.

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ORR  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_SUBI = 4'd5;
    localparam logic [3:0] OP_MOVZ = 4'd6;
    localparam logic [3:0] OP_B    = 4'd7;
    localparam logic [3:0] OP_CBZ  = 4'd8;
    localparam logic [3:0] OP_LDUR = 4'd9;
    localparam logic [3:0] OP_STUR = 4'd10;

    logic [1:0]        state;
    logic              last_seen;
    logic [ADDR_W-1:0] next_addr;

    logic [ADDR_W-1:0] mem_addr  [FIFO_DEPTH];
    logic [31:0]       mem_instr [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;

    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        enter_run;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (in_op)
            OP_AND:  word = {11'b10001010000, in_rm, in_shamt, in_rn, in_rd};
            OP_ORR:  word = {11'b10101010000, in_rm, in_shamt, in_rn, in_rd};
            OP_ADD:  word = {11'b10001011000, in_rm, in_shamt, in_rn, in_rd};
            OP_SUB:  word = {11'b11001011000, in_rm, in_shamt, in_rn, in_rd};
            OP_ADDI: word = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
            OP_SUBI: word = {10'b1101000100, in_imm[11:0], in_rn, in_rd};
            OP_MOVZ: word = {9'b110100101, in_hw, in_imm[15:0], in_rd};
            OP_B:    word = {6'b000101, in_imm[25:0]};
            OP_CBZ:  word = {8'b10110100, in_imm[18:0], in_rd};
            OP_LDUR: word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
            OP_STUR: word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
            default: legal = 1'b0;
        endcase
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign in_ready  = (state == RUN) && !fifo_full && !last_seen;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign enter_run = start && ((state == IDLE) || (state == DONE));

    // Head is masked while empty so reset shows a clean, defined output.
    assign out_addr  = fifo_empty ? BASE_ADDR : mem_addr[rd_ptr[PTR_W-1:0]];
    assign out_instr = fifo_empty ? 32'h0 : mem_instr[rd_ptr[PTR_W-1:0]];

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr[wr_ptr[PTR_W-1:0]]  <= next_addr;
            mem_instr[wr_ptr[PTR_W-1:0]] <= word;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            last_seen <= 1'b0;
            next_addr <= BASE_ADDR;
            count     <= '0;
            illegal   <= 1'b0;
        end else begin
            illegal <= accept && !legal;

            case (state)
                IDLE, DONE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (last_seen && fifo_empty) state <= DONE;
                end
                default: state <= IDLE;
            endcase

            if (enter_run) begin
                last_seen <= 1'b0;
                next_addr <= BASE_ADDR;
                count     <= '0;
            end else begin
                if (push)            next_addr <= next_addr + ADDR_W'(4);
                if (accept && in_last) last_seen <= 1'b1;
                if (pop && (count != 16'hFFFF)) count <= count + 16'd1;
            end
        end
    end

endmodule
